// File: rtl/sensor_frame_packer_pkg.sv
// Shared types and ASCII constants for the sensor frame packer.
// Frames: "D=ddd\r\n" (7 bytes) and "T=ddd,H=ddd\r\n" (13 bytes).
package sensor_frame_packer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT_ACK,
      WAIT_DONE
   } state_e;

   localparam logic [7:0] CH_D     = 8'h44;
   localparam logic [7:0] CH_T     = 8'h54;
   localparam logic [7:0] CH_H     = 8'h48;
   localparam logic [7:0] CH_EQ    = 8'h3D;
   localparam logic [7:0] CH_COMMA = 8'h2C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_ZERO  = 8'h30;

   localparam logic [3:0] LAST_DIST = 4'd6;
   localparam logic [3:0] LAST_TH   = 4'd12;

   function automatic logic [3:0] last_idx(input logic is_th);
      return is_th ? LAST_TH : LAST_DIST;
   endfunction

endpackage

// File: rtl/sensor_frame_packer_bin8_to_ascii3.sv
// Combinational 8-bit unsigned to three ASCII decimal digits.
// Double-dabble: add 3 to any BCD nibble >= 5 before each shift.
module bin8_to_ascii3
   import sensor_frame_packer_pkg::*;
(
   input  logic [7:0] i_bin,
   output logic [7:0] o_hund,
   output logic [7:0] o_tens,
   output logic [7:0] o_ones
);

   logic [19:0] sh;

   always_comb begin
      sh = {12'd0, i_bin};
      for (int i = 0; i < 8; i++) begin
         if (sh[11:8] >= 4'd5)
            sh[11:8] = sh[11:8] + 4'd3;
         if (sh[15:12] >= 4'd5)
            sh[15:12] = sh[15:12] + 4'd3;
         if (sh[19:16] >= 4'd5)
            sh[19:16] = sh[19:16] + 4'd3;
         sh = sh << 1;
      end
   end

   assign o_hund = CH_ZERO | {4'h0, sh[19:16]};
   assign o_tens = CH_ZERO | {4'h0, sh[15:12]};
   assign o_ones = CH_ZERO | {4'h0, sh[11:8]};

endmodule

// File: rtl/sensor_frame_packer.sv
// Packs distance and temperature/humidity samples into ASCII
// frames and feeds them byte by byte to a UART transmitter.
module sensor_frame_packer
   import sensor_frame_packer_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_dist_valid,
   input  logic [7:0] i_dist,
   input  logic       i_th_valid,
   input  logic [7:0] i_temp,
   input  logic [7:0] i_hum,
   input  logic       i_tx_busy,
   output logic       o_tx_start,
   output logic [7:0] o_tx_data,
   output logic       o_frame_active,
   output logic [7:0] o_drop_cnt
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

   state_e        state_q, state_d;
   logic          dist_pend_q, dist_pend_d;
   logic          th_pend_q, th_pend_d;
   logic [7:0]    dist_snap_q, dist_snap_d;
   logic [7:0]    temp_snap_q, temp_snap_d;
   logic [7:0]    hum_snap_q, hum_snap_d;
   logic [7:0]    drop_q, drop_d;
   logic          is_th_q, is_th_d;
   logic [7:0]    fa_q, fa_d;
   logic [7:0]    fb_q, fb_d;
   logic [3:0]    idx_q, idx_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic       load_dist, load_th;
   logic       drop_dist, drop_th;
   logic       advance, last_byte;
   logic [8:0] drop_sum;
   logic [7:0] a_h, a_t, a_o;
   logic [7:0] b_h, b_t, b_o;
   logic [7:0] cur_byte;

   bin8_to_ascii3 u_conv_a (
      .i_bin  (fa_q),
      .o_hund (a_h),
      .o_tens (a_t),
      .o_ones (a_o)
   );

   bin8_to_ascii3 u_conv_b (
      .i_bin  (fb_q),
      .o_hund (b_h),
      .o_tens (b_t),
      .o_ones (b_o)
   );

   assign load_dist = (state_q == LOAD) && dist_pend_q;
   assign load_th   = (state_q == LOAD) && !dist_pend_q;
   assign last_byte = (idx_q == last_idx(is_th_q));

   // A pulse landing on the edge its type is loaded is not a drop.
   assign drop_dist = i_dist_valid && dist_pend_q && !load_dist;
   assign drop_th   = i_th_valid && th_pend_q && !load_th;

   always_comb begin
      dist_pend_d = dist_pend_q;
      th_pend_d   = th_pend_q;
      dist_snap_d = dist_snap_q;
      temp_snap_d = temp_snap_q;
      hum_snap_d  = hum_snap_q;
      if (load_dist)
         dist_pend_d = 1'b0;
      if (load_th)
         th_pend_d = 1'b0;
      if (i_dist_valid) begin
         dist_pend_d = 1'b1;
         dist_snap_d = i_dist;
      end
      if (i_th_valid) begin
         th_pend_d   = 1'b1;
         temp_snap_d = i_temp;
         hum_snap_d  = i_hum;
      end
      drop_sum = {1'b0, drop_q} + {8'd0, drop_dist}
               + {8'd0, drop_th};
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_comb begin
      state_d    = state_q;
      is_th_d    = is_th_q;
      fa_d       = fa_q;
      fb_d       = fb_q;
      idx_d      = idx_q;
      tmo_d      = tmo_q;
      o_tx_start = 1'b0;
      advance    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (dist_pend_q || th_pend_q)
               state_d = LOAD;
         end
         LOAD: begin
            is_th_d = !dist_pend_q;
            fa_d    = dist_pend_q ? dist_snap_q : temp_snap_q;
            fb_d    = hum_snap_q;
            idx_d   = 4'd0;
            state_d = SEND;
         end
         SEND: begin
            if (!i_tx_busy) begin
               o_tx_start = 1'b1;
               tmo_d      = '0;
               state_d    = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (i_tx_busy)
               state_d = WAIT_DONE;
            else if (tmo_q == TMO_LAST)
               advance = 1'b1;
            else
               tmo_d = tmo_q + 1'b1;
         end
         WAIT_DONE: begin
            if (!i_tx_busy)
               advance = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (advance) begin
         if (last_byte) begin
            state_d = IDLE;
         end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SEND;
         end
      end
   end

   always_comb begin
      cur_byte = 8'h00;
      unique case (idx_q)
         4'd0:    cur_byte = is_th_q ? CH_T : CH_D;
         4'd1:    cur_byte = CH_EQ;
         4'd2:    cur_byte = a_h;
         4'd3:    cur_byte = a_t;
         4'd4:    cur_byte = a_o;
         4'd5:    cur_byte = is_th_q ? CH_COMMA : CH_CR;
         4'd6:    cur_byte = is_th_q ? CH_H : CH_LF;
         4'd7:    cur_byte = CH_EQ;
         4'd8:    cur_byte = b_h;
         4'd9:    cur_byte = b_t;
         4'd10:   cur_byte = b_o;
         4'd11:   cur_byte = CH_CR;
         4'd12:   cur_byte = CH_LF;
         default: cur_byte = 8'h00;
      endcase
   end

   assign o_frame_active = (state_q != IDLE);
   assign o_tx_data      = o_frame_active ? cur_byte : 8'h00;
   assign o_drop_cnt     = drop_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         dist_pend_q <= 1'b0;
         th_pend_q   <= 1'b0;
         dist_snap_q <= 8'h00;
         temp_snap_q <= 8'h00;
         hum_snap_q  <= 8'h00;
         drop_q      <= 8'h00;
         is_th_q     <= 1'b0;
         fa_q        <= 8'h00;
         fb_q        <= 8'h00;
         idx_q       <= 4'd0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         dist_pend_q <= dist_pend_d;
         th_pend_q   <= th_pend_d;
         dist_snap_q <= dist_snap_d;
         temp_snap_q <= temp_snap_d;
         hum_snap_q  <= hum_snap_d;
         drop_q      <= drop_d;
         is_th_q     <= is_th_d;
         fa_q        <= fa_d;
         fb_q        <= fb_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
      end
   end

endmodule

// File: tb/tb_sensor_frame_packer.sv
// Self-checking bench: vector table, directed corner sequences and
// a randomized run against a transaction-level frame model.
module tb_sensor_frame_packer;

   localparam int TMO = 16;

   logic       clk;
   logic       reset;
   logic       i_dist_valid;
   logic [7:0] i_dist;
   logic       i_th_valid;
   logic [7:0] i_temp;
   logic [7:0] i_hum;
   logic       i_tx_busy;
   logic       o_tx_start;
   logic [7:0] o_tx_data;
   logic       o_frame_active;
   logic [7:0] o_drop_cnt;

   sensor_frame_packer #(.ACK_TIMEOUT(TMO)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_dist_valid   (i_dist_valid),
      .i_dist         (i_dist),
      .i_th_valid     (i_th_valid),
      .i_temp         (i_temp),
      .i_hum          (i_hum),
      .i_tx_busy      (i_tx_busy),
      .o_tx_start     (o_tx_start),
      .o_tx_data      (o_tx_data),
      .o_frame_active (o_frame_active),
      .o_drop_cnt     (o_drop_cnt)
   );

   typedef struct {
      bit           is_th;
      logic [7:0]   a;
      logic [7:0]   b;
      int           n;
      logic [103:0] exp;
   } vec_t;

   typedef struct {
      int         c;
      logic [7:0] a;
      logic [7:0] b;
   } pls_t;

   typedef logic [7:0] bq_t[$];

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         stab_err = 0;
   int         busy_mode = 0;
   int         busy_len = 3;
   bit         rand_len = 0;
   int         busy_left = 0;
   bit         start_seen = 0;
   logic [7:0] held = 8'h00;
   logic [7:0] cap_q[$];
   int         cap_c[$];
   int         fcyc[13];

   pls_t dq[$];
   pls_t tq[$];
   bq_t  exp_q;
   int   pos = 0;
   int   drops = 0;
   int   frames = 0;
   bit   frame_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every started byte; watch data stability while busy.
   always @(negedge clk) begin
      start_seen = o_tx_start;
      if (!reset && o_tx_start) begin
         cap_q.push_back(o_tx_data);
         cap_c.push_back(cyc);
         held = o_tx_data;
      end else if (!reset && o_frame_active && i_tx_busy
                   && o_tx_data !== held) begin
         stab_err++;
      end
   end

   // UART model: busy rises the cycle after a start.
   always @(posedge clk) begin
      #1;
      if (reset || busy_mode != 0) begin
         busy_left = 0;
      end else if (start_seen) begin
         busy_left = rand_len ? int'($urandom_range(1, 4))
                              : busy_len;
      end else if (busy_left > 0) begin
         busy_left--;
      end
      i_tx_busy = (busy_left > 0);
   end

   task automatic chk(input string nm, input logic [103:0] got,
                      input logic [103:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [7:0] dig(input int v);
      return 8'(48 + v);
   endfunction

   function automatic bq_t fmt_frame(input bit is_th,
                                     input logic [7:0] a,
                                     input logic [7:0] b);
      bq_t q;
      q.push_back(is_th ? 8'h54 : 8'h44);
      q.push_back(8'h3D);
      q.push_back(dig(int'(a) / 100));
      q.push_back(dig((int'(a) / 10) % 10));
      q.push_back(dig(int'(a) % 10));
      if (is_th) begin
         q.push_back(8'h2C);
         q.push_back(8'h48);
         q.push_back(8'h3D);
         q.push_back(dig(int'(b) / 100));
         q.push_back(dig((int'(b) / 10) % 10));
         q.push_back(dig(int'(b) % 10));
      end
      q.push_back(8'h0D);
      q.push_back(8'h0A);
      return q;
   endfunction

   task automatic do_reset();
      @(posedge clk);
      #3 reset = 1'b1;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      cap_q.delete();
      cap_c.delete();
   endtask

   task automatic pulse_dist(input logic [7:0] v, output int n);
      @(posedge clk);
      #1;
      i_dist       = v;
      i_dist_valid = 1'b1;
      n            = cyc;
      @(posedge clk);
      #1 i_dist_valid = 1'b0;
   endtask

   task automatic pulse_th(input logic [7:0] t, input logic [7:0] h,
                           output int n);
      @(posedge clk);
      #1;
      i_temp     = t;
      i_hum      = h;
      i_th_valid = 1'b1;
      n          = cyc;
      @(posedge clk);
      #1 i_th_valid = 1'b0;
   endtask

   task automatic get_frame(input int n, output logic [103:0] got);
      int t = 0;
      got = '0;
      while (cap_q.size() < n && t < 2000) begin
         @(posedge clk);
         t++;
      end
      if (cap_q.size() < n) begin
         vectors++;
         miscompares++;
         $display("FAIL frame_timeout: got %0d bytes expected %0d",
                  cap_q.size(), n);
         cap_q.delete();
         cap_c.delete();
         return;
      end
      for (int i = 0; i < n; i++) begin
         got     = {got[95:0], cap_q.pop_front()};
         fcyc[i] = cap_c.pop_front();
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      while (o_frame_active && t < 1000) begin
         @(posedge clk);
         #1 t++;
      end
      if (o_frame_active) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: got active expected idle");
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic consume_caps();
      logic [7:0] b;
      int         c;
      int         k;
      while (cap_q.size() > 0) begin
         b = cap_q.pop_front();
         c = cap_c.pop_front();
         if (pos == 0) begin
            k = 0;
            while (k < dq.size() && dq[k].c <= c - 2) k++;
            if (k > 0) begin
               exp_q = fmt_frame(1'b0, dq[k-1].a, 8'd0);
               drops += k - 1;
               for (int j = 0; j < k; j++) void'(dq.pop_front());
            end else begin
               while (k < tq.size() && tq[k].c <= c - 2) k++;
               if (k == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL rand_spurious: got byte %0h expected none",
                           b);
                  continue;
               end
               exp_q = fmt_frame(1'b1, tq[k-1].a, tq[k-1].b);
               drops += k - 1;
               for (int j = 0; j < k; j++) void'(tq.pop_front());
            end
            frame_bad = 0;
         end
         if (b !== exp_q[pos] && !frame_bad) begin
            frame_bad = 1;
            $display("FAIL rand_frame%0d: byte %0d got %0h expected %0h",
                     frames, pos, b, exp_q[pos]);
         end
         pos++;
         if (pos == exp_q.size()) begin
            vectors++;
            if (frame_bad) miscompares++;
            frames++;
            pos = 0;
         end
      end
   endtask

   vec_t         vecs[9];
   logic [103:0] got;
   int           n0;
   int           n1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 8'd123, 8'd0, 7, 104'h443D3132330D0A};
      vecs[1] = '{0, 8'd0, 8'd0, 7, 104'h443D3030300D0A};
      vecs[2] = '{0, 8'd255, 8'd0, 7, 104'h443D3235350D0A};
      vecs[3] = '{0, 8'd9, 8'd0, 7, 104'h443D3030390D0A};
      vecs[4] = '{0, 8'd100, 8'd0, 7, 104'h443D3130300D0A};
      vecs[5] = '{1, 8'd25, 8'd60, 13,
                  104'h543D3032352C483D3036300D0A};
      vecs[6] = '{1, 8'd255, 8'd100, 13,
                  104'h543D3235352C483D3130300D0A};
      vecs[7] = '{1, 8'd0, 8'd9, 13,
                  104'h543D3030302C483D3030390D0A};
      vecs[8] = '{1, 8'd99, 8'd255, 13,
                  104'h543D3039392C483D3235350D0A};

      reset        = 1'b1;
      i_dist_valid = 1'b0;
      i_dist       = 8'h00;
      i_th_valid   = 1'b0;
      i_temp       = 8'h00;
      i_hum        = 8'h00;
      i_tx_busy    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start", o_tx_start, 0);
      chk("rst_data", o_tx_data, 0);
      chk("rst_active", o_frame_active, 0);
      chk("rst_drop", o_drop_cnt, 0);
      @(posedge clk);
      #3 reset = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].is_th)
            pulse_th(vecs[i].a, vecs[i].b, n0);
         else
            pulse_dist(vecs[i].a, n0);
         get_frame(vecs[i].n, got);
         chk($sformatf("vec%0d_bytes", i), got, vecs[i].exp);
         chk($sformatf("vec%0d_latency", i), fcyc[0], n0 + 3);
         wait_idle();
      end

      // Simultaneous pulses: distance goes first, then T/H.
      do_reset();
      @(posedge clk);
      #1;
      i_dist       = 8'd0;
      i_temp       = 8'd255;
      i_hum        = 8'd100;
      i_dist_valid = 1'b1;
      i_th_valid   = 1'b1;
      n0           = cyc;
      @(posedge clk);
      #1;
      i_dist_valid = 1'b0;
      i_th_valid   = 1'b0;
      get_frame(7, got);
      chk("simul_dist", got, 104'h443D3030300D0A);
      chk("simul_latency", fcyc[0], n0 + 3);
      get_frame(13, got);
      chk("simul_th", got, 104'h543D3235352C483D3130300D0A);
      wait_idle();

      // Two distance pulses during a T/H frame: one drop.
      do_reset();
      pulse_th(8'd1, 8'd2, n0);
      n1 = 0;
      while (cap_q.size() < 1 && n1 < 100) begin
         @(posedge clk);
         n1++;
      end
      pulse_dist(8'd10, n0);
      repeat (3) @(posedge clk);
      pulse_dist(8'd20, n0);
      chk("drop_one", o_drop_cnt, 1);
      get_frame(13, got);
      chk("drop_th_frame", got, 104'h543D3030312C483D3030320D0A);
      get_frame(7, got);
      chk("drop_latest", got, 104'h443D3032300D0A);
      wait_idle();

      // Busy never rises: every byte advances on the timeout.
      do_reset();
      busy_mode = 1;
      pulse_dist(8'd42, n0);
      get_frame(7, got);
      chk("tmo_frame", got, 104'h443D3034320D0A);
      for (int i = 1; i < 7; i++)
         chk($sformatf("tmo_gap%0d", i), fcyc[i] - fcyc[i-1], TMO + 1);
      wait_idle();

      // Drop counter saturates.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         i_dist       = 8'(i);
         i_dist_valid = 1'b1;
      end
      @(posedge clk);
      #1 i_dist_valid = 1'b0;
      chk("drop_sat", o_drop_cnt, 255);
      busy_mode = 0;
      do_reset();
      repeat (2) @(posedge clk);

      // Reset mid T/H frame with distance pending.
      pulse_th(8'd11, 8'd22, n0);
      n1 = 0;
      while (cap_q.size() < 4 && n1 < 200) begin
         @(posedge clk);
         n1++;
      end
      pulse_dist(8'd5, n0);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("midrst_start", o_tx_start, 0);
      chk("midrst_data", o_tx_data, 0);
      chk("midrst_active", o_frame_active, 0);
      chk("midrst_drop", o_drop_cnt, 0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      cap_q.delete();
      cap_c.delete();
      repeat (40) @(posedge clk);
      #1;
      chk("midrst_no_start", cap_q.size(), 0);
      chk("midrst_idle", o_frame_active, 0);
      pulse_dist(8'd7, n0);
      get_frame(7, got);
      chk("midrst_new", got, 104'h443D3030370D0A);
      chk("midrst_latency", fcyc[0], n0 + 3);
      wait_idle();

      // Randomized run against the transaction-level model.
      do_reset();
      rand_len = 1;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         i_dist_valid = ($urandom_range(0, 24) == 0);
         i_th_valid   = ($urandom_range(0, 24) == 0);
         if (i_dist_valid) begin
            i_dist = 8'($urandom);
            dq.push_back('{cyc, i_dist, 8'd0});
         end
         if (i_th_valid) begin
            i_temp = 8'($urandom);
            i_hum  = 8'($urandom);
            tq.push_back('{cyc, i_temp, i_hum});
         end
         consume_caps();
      end
      @(posedge clk);
      #1;
      i_dist_valid = 1'b0;
      i_th_valid   = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk);
         #1 consume_caps();
         if (dq.size() == 0 && tq.size() == 0 && pos == 0
             && !o_frame_active)
            break;
      end
      chk("rand_drained", dq.size() + tq.size() + pos, 0);
      chk("rand_drops", o_drop_cnt, (drops > 255) ? 255 : drops);
      chk("data_stable", stab_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sensor_frame_packer.md
SENSOR_FRAME_PACKER -- requirements
Module: sensor_frame_packer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, giving the cycles to wait for i_tx_busy to rise after a start.
REQ-002 SHALL have port clk  input  1  system clock (100 MHz).
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_dist_valid  input  1  one-cycle pulse: new distance sample.
REQ-005 SHALL have port i_dist  input  8  distance in cm, unsigned.
REQ-006 SHALL have port i_th_valid  input  1  one-cycle pulse: new temperature/humidity sample.
REQ-007 SHALL have port i_temp  input  8  temperature in degrees C, unsigned.
REQ-008 SHALL have port i_hum  input  8  relative humidity in %, unsigned.
REQ-009 SHALL have port i_tx_busy  input  1  UART transmitter busy.
REQ-010 SHALL have port o_tx_start  output  1  one-cycle byte-start pulse to the UART transmitter.
REQ-011 SHALL have port o_tx_data  output  8  byte to send, held stable from o_tx_start until i_tx_busy falls.
REQ-012 SHALL have port o_frame_active  output  1  high while a frame is being loaded or sent.
REQ-013 SHALL have port o_drop_cnt  output  8  count of overwritten pending samples, saturating.

Function
REQ-014 SHALL format a distance frame as "D=ddd" CR LF: 7 bytes.
REQ-015 SHALL format a T/H frame as "T=ddd,H=ddd" CR LF: 13 bytes.
REQ-016 SHALL render each ddd as three ASCII decimal digits with leading zeros kept (0 -> "000", 255 -> "255").
REQ-017 SHALL, on a valid pulse, set that type's pending flag and snapshot its data on the same edge.
REQ-018 SHALL, when a valid pulse arrives while that type is already pending, overwrite the snapshot (latest value wins) and increment o_drop_cnt, saturating at 255.
REQ-019 SHALL latch simultaneous i_dist_valid and i_th_valid pulses independently.
REQ-020 SHALL give distance priority over T/H when both are pending at frame selection.
REQ-021 SHALL use FSM states IDLE, LOAD, SEND, WAIT_ACK and WAIT_DONE.
REQ-022 SHALL move IDLE -> LOAD when any flag is pending.
REQ-023 SHALL, in LOAD, copy the selected snapshot into frame registers, clear only that pending flag, reset the byte index to 0, then go to SEND.
REQ-024 SHALL, in SEND, assert o_tx_start for exactly one cycle only when i_tx_busy=0, else hold in SEND, then go to WAIT_ACK.
REQ-025 SHALL, in WAIT_ACK, go to WAIT_DONE when i_tx_busy=1.
REQ-026 SHALL, in WAIT_ACK, treat the byte as sent and advance after ACK_TIMEOUT cycles without i_tx_busy rising.
REQ-027 SHALL, in WAIT_DONE, on i_tx_busy falling, increment the byte index and go to SEND, or to IDLE after the last byte.
REQ-028 SHALL, with the FSM in IDLE and i_tx_busy=0, raise o_tx_start in cycle N+3 for a valid pulse in cycle N.
REQ-029 SHALL let a valid pulse arriving during a frame of the same type only set pending, without altering the frame in flight.
REQ-030 SHALL never let consecutive frames interleave bytes.
REQ-031 SHALL hold o_frame_active high in LOAD, SEND, WAIT_ACK and WAIT_DONE.

Reset
REQ-032 SHALL, on reset, force the FSM to IDLE, o_tx_start=0, o_tx_data=8'h00, o_frame_active=0 and o_drop_cnt=0, and clear both pending flags and the byte index.
REQ-033 SHALL, on reset mid-frame, abandon the frame immediately, drop both pending samples, and restart only on a new valid pulse.

Structure
REQ-034 SHALL place the FSM state encoding and the ASCII constants ('D', 'T', 'H', '=', ',', CR 8'h0D, LF 8'h0A, '0' 8'h30) in a shared package.
REQ-035 SHALL contain one sub-module, bin8_to_ascii3: combinational 8-bit unsigned to three ASCII digits (double-dabble), instantiated once per converted field.

Verification
REQ-036 SHALL cover: i_dist=123 pulse, busy model 1-cycle-late -> bytes 44 3D 31 32 33 0D 0A, first start at N+3.
REQ-037 SHALL cover: i_temp=25, i_hum=60 -> bytes 54 3D 30 32 35 2C 48 3D 30 36 30 0D 0A.
REQ-038 SHALL cover: simultaneous dist=0 and th=(255,100) -> "D=000" frame fully, then "T=255,H=100".
REQ-039 SHALL cover: during a T/H frame, dist pulses 10 then 20 -> o_drop_cnt=1, next frame "D=020".
REQ-040 SHALL cover: busy never asserted -> each byte advances after 16 cycles and the frame completes.
REQ-041 SHALL cover: reset at byte 4 of a T/H frame with dist pending -> outputs at reset values, no further start until a new pulse.
